ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RST_FETCH, default 1, SHALL make the block start a fetch automatically on the first cycle after reset deasserts (0 = wait for fetch_start).
REQ-002 clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pc_i  input  32  current PC from the PC-select register, held stable while fetch_start is asserted.
REQ-005 fetch_start  input  1  one-cycle pulse: previous instruction committed, so fetch at pc_i.
REQ-006 mem_req_valid  output  1  instruction-memory read request valid.
REQ-007 mem_req_ready  input  1  memory accepts the request.
REQ-008 mem_req_addr  output  32  read address.
REQ-009 mem_rsp_valid  input  1  read data valid.
REQ-010 mem_rsp_data  input  32  read data.
REQ-011 mem_rsp_err  input  1  bus error qualifying mem_rsp_valid.
REQ-012 inst_valid  output  1  fetched instruction available to decode.
REQ-013 inst_ready  input  1  decode consumes the instruction.
REQ-014 inst_o  output  32  instruction word.
REQ-015 inst_pc  output  32  PC of inst_o.
REQ-016 fetch_err  output  1  fault flag accompanying inst_valid.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT and OUT.
REQ-019 IDLE: on fetch_start, the block SHALL latch pc_i into an internal address register and go to REQ on the next cycle.
REQ-020 REQ: mem_req_valid SHALL be 1 and mem_req_addr SHALL equal the latched address; the handshake completes when mem_req_valid and mem_req_ready are both 1 in the same cycle, and the state then moves to WAIT.
REQ-021 mem_req_valid and mem_req_addr SHALL stay stable until the handshake completes.
REQ-022 WAIT: on mem_rsp_valid, the block SHALL capture mem_rsp_data into inst_o and mem_rsp_err into fetch_err, and go to OUT.
REQ-023 A response that arrives in the same cycle as the request handshake SHALL NOT be accepted; responses are taken in WAIT only.
REQ-024 OUT: inst_valid SHALL be 1, and inst_o, inst_pc and fetch_err SHALL stay stable until inst_ready is sampled high; the state then moves to IDLE.
REQ-025 Minimum latency, from the fetch_start pulse to inst_valid with ready memory and a next-cycle response, SHALL be 3 cycles.
REQ-026 A fetch_start received while busy SHALL be ignored; an assertion-time check SHALL flag it.
REQ-027 inst_valid SHALL be 0 in all states except OUT.
REQ-028 inst_pc SHALL equal the latched address of the current fetch.
REQ-029 All address arithmetic is 32-bit with no wrap handling; 0xFFFF_FFFC SHALL be fetched normally.

Reset
REQ-030 While rst=1: state=IDLE; mem_req_valid=0; inst_valid=0; fetch_err=0; inst_o=0x0000_0013 (NOP); inst_pc=0; mem_req_addr=0.
REQ-031 Reset asserted in any state SHALL abort the fetch, and a late mem_rsp_valid after reset SHALL be ignored.
REQ-032 With RST_FETCH=1, the first cycle after reset SHALL behave as an IDLE cycle with fetch_start=1.

Configuration
REQ-033 The macro IFU_MISALIGN_CHECK_EN SHALL, when defined, make a latch with pc_i[1:0]!=0 skip REQ and WAIT and go directly to OUT with fetch_err=1 and inst_o=0x0000_0013, issuing no memory request.
REQ-034 When IFU_MISALIGN_CHECK_EN is undefined, the block SHALL drive pc_i[1:0] unchanged on mem_req_addr and fetch normally.

Verification
REQ-035 Basic fetch: fetch_start with pc_i=0x8000_0000, ready=1, response one cycle later with data=0x0010_0093 -> inst_valid in the 3rd cycle, inst_o=0x0010_0093, inst_pc=0x8000_0000, fetch_err=0.
REQ-036 Backpressure: mem_req_ready low for 4 cycles, then inst_ready low for 3 cycles -> request address stable for 5 cycles and inst_o stable for 4 cycles, with a single handshake each.
REQ-037 Bus error: mem_rsp_err=1 together with data 0xDEAD_BEEF -> inst_valid=1 and fetch_err=1.
REQ-038 Reset mid-WAIT: rst pulsed in WAIT, then mem_rsp_valid arrives -> inst_valid stays 0, state=IDLE, and a new fetch_start fetches correctly.
REQ-039 Misalign: pc_i=0x8000_0002 -> with IFU_MISALIGN_CHECK_EN defined, no mem_req_valid and fetch_err=1; with it undefined, mem_req_addr=0x8000_0002.
REQ-040 Ignored start: a second fetch_start while in WAIT -> exactly one inst_valid, with inst_pc equal to the first pc_i.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch FSM (IDLE/REQ/WAIT/OUT).
// Optional macro IFU_MISALIGN_CHECK_EN: misaligned PC faults with no bus access.
// Ports: clk, rst (sync, active-high); pc_i/fetch_start start a fetch;
//   mem_req_* read request (valid/ready), mem_rsp_* read response;
//   inst_valid/inst_ready hand inst_o, inst_pc, fetch_err to decode; busy.
module ifu_fetch #(
  parameter int unsigned RST_FETCH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        fetch_start,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc,
  output logic        fetch_err,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [31:0] addr_q;
  logic [31:0] inst_q;
  logic        err_q;
  logic        boot_q;
  logic        start;
  logic        misal;

  // boot_q marks the first cycle out of reset so it can act as a start
  assign start = fetch_start | ((RST_FETCH != 0) & boot_q);

`ifdef IFU_MISALIGN_CHECK_EN
  assign misal = |pc_i[1:0];
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = misal ? OUT : REQ;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_rsp_valid) state_d = OUT;
      OUT:  if (inst_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      inst_q  <= NOP;
      err_q   <= 1'b0;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      boot_q  <= 1'b0;
      if (state_q == IDLE && start) begin
        addr_q <= pc_i;
        if (misal) begin
          inst_q <= NOP;
          err_q  <= 1'b1;
        end
      end
      // responses are only taken once the request has been accepted
      if (state_q == WAIT && mem_rsp_valid) begin
        inst_q <= mem_rsp_data;
        err_q  <= mem_rsp_err;
      end
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = addr_q;
  assign inst_valid    = (state_q == OUT);
  assign inst_o        = inst_q;
  assign inst_pc       = addr_q;
  assign fetch_err     = err_q;
  assign busy          = (state_q != IDLE);

`ifndef SYNTHESIS
  // a start while busy is dropped; record it and make sure it is harmless
  cover property (@(posedge clk) disable iff (rst)
    busy && fetch_start);

  a_ignore_start: assert property (@(posedge clk) disable iff (rst)
    busy && fetch_start |=> $stable(addr_q));

  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    mem_req_valid && !mem_req_ready |=>
      mem_req_valid && $stable(mem_req_addr));

  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    inst_valid && !inst_ready |=>
      inst_valid && $stable(inst_o) && $stable(fetch_err));
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized self-checking bench for ifu_fetch.
// Each fetch is checked against a cycle schedule derived from its delays.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        fetch_start;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] inst_pc;
  logic        fetch_err;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .fetch_start  (fetch_start),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .mem_rsp_err  (mem_rsp_err),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_o       (inst_o),
    .inst_pc      (inst_pc),
    .fetch_err    (fetch_err),
    .busy         (busy)
  );

  // One fetch. Index k counts falling edges from the start cycle (k=0).
  // Expected timeline: request at 1..1+rs, accepted at 1+rs, response
  // rd cycles later, instruction shown from t_out for os+1 cycles.
  task automatic run_fetch(
    input logic [31:0] pc,
    input logic [31:0] data,
    input logic        err,
    input int          rs,
    input int          rd,
    input int          os,
    input int          kx,
    input bit          auto_go
  );
    bit mis;
    int t_out;
    int t_end;
    int hs;
    bit e_req;
    bit e_wait;
    bit e_out;
    bit e_busy;
    bit give;
`ifdef IFU_MISALIGN_CHECK_EN
    mis = (pc[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    t_out = mis ? 1 : 3 + rs + rd;
    t_end = t_out + os + 1;
    hs = 0;
    for (int k = 0; k <= t_end; k++) begin
      @(negedge clk);
      e_req  = !mis && k >= 1 && k <= 1 + rs;
      e_wait = !mis && k >= 2 + rs && k < t_out;
      e_out  = k >= t_out && k <= t_out + os;
      e_busy = k >= 1 && k <= t_out + os;
      nvec++;
      if ({mem_req_valid, inst_valid, busy} !== {e_req, e_out, e_busy}) begin
        nerr++;
        $display("FAIL ctl pc=%h k=%0d req/val/busy got=%b exp=%b",
          pc, k, {mem_req_valid, inst_valid, busy}, {e_req, e_out, e_busy});
      end
      if (e_req) begin
        nvec++;
        if (mem_req_addr !== pc) begin
          nerr++;
          $display("FAIL addr k=%0d got=%h exp=%h", k, mem_req_addr, pc);
        end
      end
      if (e_out) begin
        nvec++;
        if ({inst_o, inst_pc, fetch_err} !==
            {(mis ? NOP : data), pc, (mis | err)}) begin
          nerr++;
          $display("FAIL inst k=%0d got=%h/%h/%b exp=%h/%h/%b", k,
            inst_o, inst_pc, fetch_err, (mis ? NOP : data), pc, (mis | err));
        end
      end
      rst = 1'b0;
      fetch_start = (k == 0 && !auto_go) || (kx != 0 && k == kx);
      pc_i = (k == 0) ? pc : $urandom;
      mem_req_ready = e_req ? (k == 1 + rs) : 1'($urandom);
      give = e_wait && (k == t_out - 1);
      if (k == 0 && auto_go)
        mem_rsp_valid = 1'b1;
      else
        mem_rsp_valid = e_wait ? give : 1'($urandom);
      mem_rsp_data = give ? data : $urandom;
      mem_rsp_err = give ? err : 1'($urandom);
      inst_ready = e_out ? (k == t_out + os) : 1'($urandom);
      if (mem_req_valid && mem_req_ready) hs++;
    end
    nvec++;
    if (hs != (mis ? 0 : 1)) begin
      nerr++;
      $display("FAIL handshakes pc=%h got=%0d exp=%0d", pc, hs, mis ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if ({mem_req_valid, inst_valid, fetch_err, busy} !== 4'b0000) begin
        nerr++;
        $display("FAIL rst_ctl got=%b exp=0000",
          {mem_req_valid, inst_valid, fetch_err, busy});
      end
      nvec++;
      if ({inst_o, inst_pc, mem_req_addr} !== {NOP, 32'h0, 32'h0}) begin
        nerr++;
        $display("FAIL rst_data got=%h/%h/%h exp=%h/0/0",
          inst_o, inst_pc, mem_req_addr, NOP);
      end
      fetch_start = 1'($urandom);
      pc_i = $urandom;
      mem_req_ready = 1'($urandom);
      mem_rsp_valid = 1'($urandom);
      mem_rsp_data = $urandom;
      inst_ready = 1'($urandom);
    end
    fetch_start = 1'b0;
  endtask

  task automatic test_auto_start();
    run_fetch(32'h0000_1000, 32'h0000_0517, 1'b0, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic test_basic();
    run_fetch(32'h8000_0000, 32'h0010_0093, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_fetch(32'h8000_0040, 32'h0020_8133, 1'b0, 4, 0, 3, 0, 1'b0);
  endtask

  task automatic test_bus_error();
    run_fetch(32'h8000_0100, 32'hDEAD_BEEF, 1'b1, 1, 2, 1, 0, 1'b0);
  endtask

  task automatic test_ignored_start();
    run_fetch(32'h8000_0200, 32'h0030_0193, 1'b0, 0, 2, 0, 2, 1'b0);
  endtask

  task automatic test_misalign();
    run_fetch(32'h8000_0002, 32'h0040_0213, 1'b0, 0, 0, 1, 0, 1'b0);
  endtask

  task automatic test_top_addr();
    run_fetch(32'hFFFF_FFFC, 32'h0050_0293, 1'b0, 1, 1, 0, 0, 1'b0);
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    pc_i = 32'h8000_0300;
    fetch_start = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    fetch_start = 1'b0;
    pc_i = $urandom;
    nvec++;
    if (mem_req_valid !== 1'b1) begin
      nerr++;
      $display("FAIL rw_req got=%b exp=1", mem_req_valid);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    nvec++;
    if ({mem_req_valid, inst_valid, busy} !== 3'b001) begin
      nerr++;
      $display("FAIL rw_wait got=%b exp=001",
        {mem_req_valid, inst_valid, busy});
    end
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if ({mem_req_valid, inst_valid, fetch_err, busy, inst_o} !==
        {4'b0000, NOP}) begin
      nerr++;
      $display("FAIL rw_rst got=%b/%h exp=0000/%h",
        {mem_req_valid, inst_valid, fetch_err, busy}, inst_o, NOP);
    end
    run_fetch(32'h8000_0400, 32'h0060_0313, 1'b0, 1, 0, 0, 0, 1'b1);
    run_fetch(32'h8000_0500, 32'h0070_0393, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] pc;
    int rs;
    int rd;
    int os;
    int kx;
    for (int n = 0; n < 40; n++) begin
      pc = $urandom;
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      rs = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      os = $urandom_range(0, 3);
      kx = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 1 + os);
      run_fetch(pc, $urandom, 1'($urandom), rs, rd, os, kx, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    fetch_start = 1'b0;
    pc_i = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    mem_rsp_err = 1'b0;
    inst_ready = 1'b0;
    test_reset();
    test_auto_start();
    test_basic();
    test_backpressure();
    test_bus_error();
    test_ignored_start();
    test_misalign();
    test_top_addr();
    test_reset_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
